ifetch_sram_ctrl: RTL

- Instruction-fetch sequencer for the IF stage. It reads 16-bit instructions from external RAM2 using multi-cycle SRAM timing and presents one buffered instruction and its PC to the IF/ID latch through a valid/ready handshake.
- Handles branch redirects from the jump control. Yields RAM2 to the data-memory path on demand.
- Replaces the combinational instruction ROM path for programs loaded into RAM2.

---
 rtl/ifetch_sram_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ifetch_sram_ctrl.sv
// Instruction-fetch sequencer: reads 16-bit instructions from RAM2 with a
// multi-cycle SRAM read and hands one buffered instruction to the IF/ID latch.
module ifetch_sram_ctrl #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_INST    = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_pc,
    input  logic [15:0] set_pc_addr,
    input  logic        inst_ready,
    input  logic        mem_yield,
    input  logic [15:0] ram2_data_in,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [15:0] pc,
    output logic [17:0] ram2_addr,
    output logic        ram2_en,
    output logic        ram2_oe,
    output logic        ram2_rw,
    output logic        ram2_owned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_r,      state_s;
    logic [15:0] fetch_pc_r,   fetch_pc_s;
    logic [3:0]  wait_cnt_r,   wait_cnt_s;
    logic        inst_valid_r, inst_valid_s;
    logic [15:0] inst_r,       inst_s;
    logic [15:0] pc_r,         pc_s;
    logic [17:0] ram2_addr_r,  ram2_addr_s;
    logic        ram2_en_r,    ram2_en_s;
    logic        ram2_oe_r,    ram2_oe_s;
    logic        ram2_owned_r, ram2_owned_s;
    logic        ram2_rw_r;

    // RAM2 is 18 bits wide; instruction space occupies the low 64K words.
    function automatic logic [17:0] word_addr(input logic [15:0] fetch_addr);
        return {2'b00, fetch_addr};
    endfunction

    // Next-state and next-output computation; the bus is only ever driven
    // from READ, so ram2_owned tracks ~ram2_en by construction.
    always_comb begin
        state_s      = state_r;
        fetch_pc_s   = fetch_pc_r;
        wait_cnt_s   = wait_cnt_r;
        inst_valid_s = inst_valid_r;
        inst_s       = inst_r;
        pc_s         = pc_r;
        ram2_addr_s  = ram2_addr_r;
        ram2_en_s    = ram2_en_r;
        ram2_oe_s    = ram2_oe_r;
        ram2_owned_s = ram2_owned_r;

        if (set_pc) begin
            fetch_pc_s   = set_pc_addr;
            inst_valid_s = 1'b0;
            inst_s       = NOP_INST;
            if (!mem_yield) begin
                state_s      = READ;
                ram2_addr_s  = word_addr(set_pc_addr);
                ram2_en_s    = 1'b0;
                ram2_oe_s    = 1'b0;
                ram2_owned_s = 1'b1;
                wait_cnt_s   = WAIT_LOAD;
            end else begin
                state_s      = IDLE;
                ram2_en_s    = 1'b1;
                ram2_oe_s    = 1'b1;
                ram2_owned_s = 1'b0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (!mem_yield) begin
                        state_s      = READ;
                        ram2_addr_s  = word_addr(fetch_pc_r);
                        ram2_en_s    = 1'b0;
                        ram2_oe_s    = 1'b0;
                        ram2_owned_s = 1'b1;
                        wait_cnt_s   = WAIT_LOAD;
                    end else begin
                        state_s = IDLE;
                    end
                end
                READ: begin
                    if (mem_yield) begin
                        // fetch_pc is kept so the aborted word is refetched later
                        state_s      = IDLE;
                        ram2_en_s    = 1'b1;
                        ram2_oe_s    = 1'b1;
                        ram2_owned_s = 1'b0;
                    end else if (wait_cnt_r == 4'd0) begin
                        state_s      = FULL;
                        inst_s       = ram2_data_in;
                        pc_s         = fetch_pc_r;
                        inst_valid_s = 1'b1;
                        fetch_pc_s   = fetch_pc_r + 16'd1;
                        ram2_en_s    = 1'b1;
                        ram2_oe_s    = 1'b1;
                        ram2_owned_s = 1'b0;
                    end else begin
                        wait_cnt_s = wait_cnt_r - 4'd1;
                    end
                end
                FULL: begin
                    if (inst_ready) begin
                        inst_valid_s = 1'b0;
                        inst_s       = NOP_INST;
                        if (!mem_yield) begin
                            state_s      = READ;
                            ram2_addr_s  = word_addr(fetch_pc_r);
                            ram2_en_s    = 1'b0;
                            ram2_oe_s    = 1'b0;
                            ram2_owned_s = 1'b1;
                            wait_cnt_s   = WAIT_LOAD;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        state_s = FULL;
                    end
                end
                default: begin
                    state_s      = IDLE;
                    inst_valid_s = 1'b0;
                    inst_s       = NOP_INST;
                    ram2_en_s    = 1'b1;
                    ram2_oe_s    = 1'b1;
                    ram2_owned_s = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            fetch_pc_r   <= RESET_PC;
            wait_cnt_r   <= 4'd0;
            inst_valid_r <= 1'b0;
            inst_r       <= NOP_INST;
            pc_r         <= 16'h0000;
            ram2_addr_r  <= 18'h00000;
            ram2_en_r    <= 1'b1;
            ram2_oe_r    <= 1'b1;
            ram2_owned_r <= 1'b0;
            ram2_rw_r    <= 1'b1;
        end else begin
            state_r      <= state_s;
            fetch_pc_r   <= fetch_pc_s;
            wait_cnt_r   <= wait_cnt_s;
            inst_valid_r <= inst_valid_s;
            inst_r       <= inst_s;
            pc_r         <= pc_s;
            ram2_addr_r  <= ram2_addr_s;
            ram2_en_r    <= ram2_en_s;
            ram2_oe_r    <= ram2_oe_s;
            ram2_owned_r <= ram2_owned_s;
            ram2_rw_r    <= 1'b1;
        end
    end

    assign inst_valid = inst_valid_r;
    assign inst       = inst_r;
    assign pc         = pc_r;
    assign ram2_addr  = ram2_addr_r;
    assign ram2_en    = ram2_en_r;
    assign ram2_oe    = ram2_oe_r;
    assign ram2_rw    = ram2_rw_r;
    assign ram2_owned = ram2_owned_r;

endmodule
